// File: rtl/parcel_color_classifier.sv
// Averages batches of VEML r/g/b samples, classifies each batch as red/blue/none/ambiguous
// and commits a parcel colour once CONFIRM consecutive batches agree.
module parcel_color_classifier #(
  parameter int          NUM_SAMPLES = 4,
  parameter int          CONFIRM     = 2,
  parameter logic [15:0] MARGIN      = 16'd64,
  parameter logic [17:0] MIN_LUM     = 18'd256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic [15:0] veml_r,
  input  logic [15:0] veml_g,
  input  logic [15:0] veml_b,
  input  logic        veml_valid,
  output logic        veml_accept,
  output logic        parcel_color,
  output logic        veml_ready,
  output logic        color_update
);

  localparam int LOG2 = $clog2(NUM_SAMPLES);
  localparam int SW   = 16 + LOG2;
  localparam logic [LOG2-1:0] LAST_SAMPLE = LOG2'(NUM_SAMPLES - 1);
  localparam logic [3:0]      CONFIRM_C   = 4'(CONFIRM);

  typedef enum logic {ACCUM, CLASSIFY} state_t;
  typedef enum logic [1:0] {CLS_NONE, CLS_RED, CLS_BLUE, CLS_AMBIG} cls_t;

  state_t          state, state_next;
  logic [SW-1:0]   sum_r, sum_g, sum_b;
  logic [LOG2-1:0] sample_cnt;
  cls_t            cand, cand_next, cls;
  logic [3:0]      conf_cnt, conf_next;
  logic            commit, color_next, ready_next;
  logic [15:0]     avg_r, avg_g, avg_b;
  logic [17:0]     lum;
  logic            transfer;

  assign veml_accept = rst && (state == ACCUM);
  assign transfer    = veml_valid && veml_accept;

  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      ACCUM:    if (transfer && sample_cnt == LAST_SAMPLE) state_next = CLASSIFY;
      CLASSIFY: state_next = ACCUM;
      default:  state_next = ACCUM;
    endcase
    if (clear) state_next = ACCUM;
  end

  // Averages are truncating shifts; 18-bit compares keep sum+MARGIN and the luminance from wrapping.
  assign avg_r = 16'(sum_r >> LOG2);
  assign avg_g = 16'(sum_g >> LOG2);
  assign avg_b = 16'(sum_b >> LOG2);
  assign lum   = 18'(avg_r) + 18'(avg_g) + 18'(avg_b);

  always_comb begin
    cls = CLS_AMBIG;
    if (lum < MIN_LUM)                                cls = CLS_NONE;
    else if (18'(avg_r) > 18'(avg_b) + 18'(MARGIN))   cls = CLS_RED;
    else if (18'(avg_b) > 18'(avg_r) + 18'(MARGIN))   cls = CLS_BLUE;
  end

  // Commit happens only on the batch that brings the count up to CONFIRM; saturated runs stay quiet.
  always_comb begin
    cand_next  = cand;
    conf_next  = conf_cnt;
    commit     = 1'b0;
    color_next = parcel_color;
    ready_next = veml_ready;
    if (cls == cand) begin
      if (conf_cnt < CONFIRM_C) begin
        conf_next = conf_cnt + 4'd1;
        commit    = (conf_next == CONFIRM_C);
      end
    end else begin
      cand_next = cls;
      conf_next = 4'd1;
      commit    = (CONFIRM_C == 4'd1);
    end
    if (commit) begin
      case (cls)
        CLS_RED:  begin color_next = 1'b0; ready_next = 1'b1; end
        CLS_BLUE: begin color_next = 1'b1; ready_next = 1'b1; end
        CLS_NONE: ready_next = 1'b0;
        default:  ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ACCUM;
    else      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_r <= '0; sum_g <= '0; sum_b <= '0;
      sample_cnt   <= '0;
      cand         <= CLS_NONE;
      conf_cnt     <= '0;
      parcel_color <= 1'b0;
      veml_ready   <= 1'b0;
      color_update <= 1'b0;
    end else if (clear) begin
      sum_r <= '0; sum_g <= '0; sum_b <= '0;
      sample_cnt   <= '0;
      cand         <= CLS_NONE;
      conf_cnt     <= '0;
      parcel_color <= 1'b0;
      veml_ready   <= 1'b0;
      color_update <= 1'b0;
    end else begin
      color_update <= 1'b0;
      case (state)
        ACCUM: begin
          if (transfer) begin
            sum_r      <= sum_r + SW'(veml_r);
            sum_g      <= sum_g + SW'(veml_g);
            sum_b      <= sum_b + SW'(veml_b);
            sample_cnt <= sample_cnt + LOG2'(1);
          end
        end
        CLASSIFY: begin
          sum_r <= '0; sum_g <= '0; sum_b <= '0;
          cand         <= cand_next;
          conf_cnt     <= conf_next;
          parcel_color <= color_next;
          veml_ready   <= ready_next;
          color_update <= (color_next != parcel_color) || (ready_next != veml_ready);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_parcel_color_classifier.sv
// Self-checking bench: batch table with fixed expectations, directed reset/clear/back-pressure
// sequences, and a random phase checked every cycle against a transaction-level model.
module tb_parcel_color_classifier;

  localparam int NUM     = 4;
  localparam int CONFIRM = 2;
  localparam int MARGIN  = 64;
  localparam int MIN_LUM = 256;

  localparam int C_NONE  = 0;
  localparam int C_RED   = 1;
  localparam int C_BLUE  = 2;
  localparam int C_AMBIG = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] veml_r = '0, veml_g = '0, veml_b = '0;
  logic        veml_valid = 1'b0;
  logic        veml_accept, parcel_color, veml_ready, color_update;

  parcel_color_classifier #(
    .NUM_SAMPLES(NUM), .CONFIRM(CONFIRM), .MARGIN(16'(MARGIN)), .MIN_LUM(18'(MIN_LUM))
  ) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .veml_r(veml_r), .veml_g(veml_g), .veml_b(veml_b),
    .veml_valid(veml_valid), .veml_accept(veml_accept),
    .parcel_color(parcel_color), .veml_ready(veml_ready), .color_update(color_update)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    else passed++;
  endtask

  // ---------------- reference model (transaction level) ----------------
  int  m_samples_r[$], m_samples_g[$], m_samples_b[$];
  int  m_history[$];      // batch classes since reset/clear
  bit  m_batch_pending;   // a full batch waits for its classify cycle
  bit  m_color, m_ready, m_upd;

  function automatic void model_reset();
    m_samples_r.delete(); m_samples_g.delete(); m_samples_b.delete();
    m_history.delete();
    m_batch_pending = 1'b0;
    m_color = 1'b0; m_ready = 1'b0; m_upd = 1'b0;
  endfunction

  function automatic int batch_class();
    int sr = 0, sg = 0, sb = 0, ar, ag, ab;
    foreach (m_samples_r[i]) begin
      sr += m_samples_r[i]; sg += m_samples_g[i]; sb += m_samples_b[i];
    end
    ar = sr / NUM; ag = sg / NUM; ab = sb / NUM;
    if (ar + ag + ab < MIN_LUM) return C_NONE;
    if (ar > ab + MARGIN)       return C_RED;
    if (ab > ar + MARGIN)       return C_BLUE;
    return C_AMBIG;
  endfunction

  // Commit when the trailing run of identical classes has length exactly CONFIRM.
  function automatic void classify_batch();
    int c = batch_class();
    int run = 0;
    bit nc, nr;
    m_history.push_back(c);
    for (int i = m_history.size() - 1; i >= 0; i--) begin
      if (m_history[i] != c) break;
      run++;
    end
    nc = m_color; nr = m_ready;
    if (run == CONFIRM) begin
      if (c == C_RED)       begin nc = 1'b0; nr = 1'b1; end
      else if (c == C_BLUE) begin nc = 1'b1; nr = 1'b1; end
      else if (c == C_NONE) nr = 1'b0;
    end
    m_upd   = (nc != m_color) || (nr != m_ready);
    m_color = nc; m_ready = nr;
    m_samples_r.delete(); m_samples_g.delete(); m_samples_b.delete();
    m_batch_pending = 1'b0;
  endfunction

  function automatic void model_edge(input bit v, input bit c, input int r, input int g, input int b);
    if (c) begin
      model_reset();
    end else if (m_batch_pending) begin
      classify_batch();
    end else begin
      m_upd = 1'b0;
      if (v) begin
        m_samples_r.push_back(r); m_samples_g.push_back(g); m_samples_b.push_back(b);
        if (m_samples_r.size() == NUM) m_batch_pending = 1'b1;
      end
    end
  endfunction

  // One clock cycle of stimulus, with the model stepped and all outputs compared.
  task automatic drive(input bit v, input bit c, input logic [15:0] r, input logic [15:0] g,
                       input logic [15:0] b);
    veml_valid = v; clear = c; veml_r = r; veml_g = g; veml_b = b;
    @(posedge clk);
    model_edge(v, c, int'(r), int'(g), int'(b));
    #1;
    check("veml_accept",  veml_accept,  !m_batch_pending);
    check("parcel_color", parcel_color, m_color);
    check("veml_ready",   veml_ready,   m_ready);
    check("color_update", color_update, m_upd);
  endtask

  task automatic run_batch(input logic [15:0] r, input logic [15:0] g, input logic [15:0] b);
    for (int i = 0; i < NUM; i++) drive(1'b1, 1'b0, r, g, b);
    drive(1'b0, 1'b0, '0, '0, '0);
  endtask

  typedef struct {
    logic [15:0] r, g, b;
    logic        color, ready, upd;
  } vec_t;

  vec_t tbl[26];

  initial begin
    logic [15:0] hr, hg, hb;
    bit hold;
    int mode;

    // {r, g, b, expected colour, ready, update pulse} after each batch
    tbl[0]  = '{1000, 200, 100, 0, 0, 0};   // red, candidate only
    tbl[1]  = '{1000, 200, 100, 0, 1, 1};   // red committed
    tbl[2]  = '{1000, 200, 100, 0, 1, 0};   // saturated, no recommit
    tbl[3]  = '{100, 200, 900, 0, 1, 0};
    tbl[4]  = '{100, 200, 900, 1, 1, 1};    // blue committed
    tbl[5]  = '{500, 200, 480, 1, 1, 0};    // ambiguous run
    tbl[6]  = '{500, 200, 480, 1, 1, 0};
    tbl[7]  = '{500, 200, 480, 1, 1, 0};
    tbl[8]  = '{500, 200, 480, 1, 1, 0};
    tbl[9]  = '{500, 200, 480, 1, 1, 0};
    tbl[10] = '{500, 200, 480, 1, 1, 0};
    tbl[11] = '{1000, 200, 100, 1, 1, 0};   // alternating red/blue never confirms
    tbl[12] = '{100, 200, 900, 1, 1, 0};
    tbl[13] = '{1000, 200, 100, 1, 1, 0};
    tbl[14] = '{100, 200, 900, 1, 1, 0};
    tbl[15] = '{50, 50, 50, 1, 1, 0};       // dark
    tbl[16] = '{50, 50, 50, 1, 0, 1};       // ready drops, colour held
    tbl[17] = '{164, 0, 100, 1, 0, 0};      // difference == MARGIN: ambiguous
    tbl[18] = '{165, 0, 100, 1, 0, 0};      // difference == MARGIN+1: red
    tbl[19] = '{165, 0, 100, 0, 1, 1};
    tbl[20] = '{100, 55, 100, 0, 1, 0};     // lum 255: none
    tbl[21] = '{100, 55, 100, 0, 0, 1};
    tbl[22] = '{100, 56, 100, 0, 0, 0};     // lum 256: present, ambiguous
    tbl[23] = '{65535, 0, 65535, 0, 0, 0};  // r+MARGIN must not wrap
    tbl[24] = '{65535, 0, 65535, 0, 0, 0};
    tbl[25] = '{65535, 65535, 0, 0, 0, 0};  // red candidate, full-scale sums

    model_reset();
    #1;
    check("reset accept low", veml_accept, 1'b0);
    check("reset color",      parcel_color, 1'b0);
    check("reset ready",      veml_ready, 1'b0);
    check("reset update",     color_update, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("accept after release", veml_accept, 1'b1);

    foreach (tbl[i]) begin
      run_batch(tbl[i].r, tbl[i].g, tbl[i].b);
      check($sformatf("tbl[%0d] color", i),  parcel_color, tbl[i].color);
      check($sformatf("tbl[%0d] ready", i),  veml_ready,   tbl[i].ready);
      check($sformatf("tbl[%0d] update", i), color_update, tbl[i].upd);
      drive(1'b0, 1'b0, '0, '0, '0);
      check($sformatf("tbl[%0d] single pulse", i), color_update, 1'b0);
    end

    // Asynchronous reset in the middle of a batch
    run_batch(100, 200, 900);
    run_batch(100, 200, 900);
    check("pre-reset blue", {parcel_color, veml_ready}, 2'b11);
    drive(1'b1, 1'b0, 1000, 0, 0);
    drive(1'b1, 1'b0, 1000, 0, 0);
    #3 rst = 1'b0;
    #1;
    check("async reset color", parcel_color, 1'b0);
    check("async reset ready", veml_ready, 1'b0);
    check("async reset accept", veml_accept, 1'b0);
    check("async reset update", color_update, 1'b0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < NUM - 1; i++) drive(1'b1, 1'b0, 1000, 0, 0);
    check("post-reset partial accept", veml_accept, 1'b1);
    drive(1'b1, 1'b0, 1000, 0, 0);
    check("post-reset classify", veml_accept, 1'b0);
    drive(1'b0, 1'b0, '0, '0, '0);

    // Dark after blue holds colour; then clear together with valid
    run_batch(100, 200, 900);
    run_batch(100, 200, 900);
    run_batch(50, 50, 50);
    run_batch(50, 50, 50);
    check("dark held color", parcel_color, 1'b1);
    check("dark ready",      veml_ready, 1'b0);
    drive(1'b1, 1'b0, 1000, 200, 100);
    drive(1'b1, 1'b0, 1000, 200, 100);
    drive(1'b1, 1'b1, 1000, 200, 100);
    check("clear color",  parcel_color, 1'b0);
    check("clear ready",  veml_ready, 1'b0);
    check("clear update", color_update, 1'b0);
    for (int i = 0; i < NUM - 1; i++) drive(1'b1, 1'b0, 1000, 200, 100);
    check("post-clear partial accept", veml_accept, 1'b1);
    drive(1'b1, 1'b0, 1000, 200, 100);
    check("post-clear classify", veml_accept, 1'b0);
    drive(1'b0, 1'b0, '0, '0, '0);

    // Back-pressure: valid held through CLASSIFY cycles
    drive(1'b0, 1'b1, '0, '0, '0);
    for (int i = 0; i < 2 * (NUM + 1) - 1; i++) drive(1'b1, 1'b0, 1000, 200, 100);
    check("bp before commit", veml_ready, 1'b0);
    drive(1'b1, 1'b0, 1000, 200, 100);
    check("bp commit ready",  veml_ready, 1'b1);
    check("bp commit pulse",  color_update, 1'b1);
    drive(1'b0, 1'b0, '0, '0, '0);

    // Random phase: stable-until-accepted samples from drifting colour templates
    hold = 1'b0; hr = '0; hg = '0; hb = '0; mode = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      bit v, c, acc;
      if ($urandom_range(0, 15) == 0) mode = $urandom_range(0, 4);
      c = ($urandom_range(0, 99) == 0);
      if (hold) begin
        v = 1'b1;
      end else begin
        v = ($urandom_range(0, 3) != 0);
        case (mode)
          0: begin hr = 16'($urandom_range(700, 1200)); hg = 16'($urandom_range(0, 400)); hb = 16'($urandom_range(0, 300)); end
          1: begin hr = 16'($urandom_range(0, 300)); hg = 16'($urandom_range(0, 400)); hb = 16'($urandom_range(700, 1200)); end
          2: begin hr = 16'($urandom_range(300, 500)); hg = 16'($urandom_range(0, 100)); hb = 16'($urandom_range(300, 500)); end
          3: begin hr = 16'($urandom_range(0, 90)); hg = 16'($urandom_range(0, 90)); hb = 16'($urandom_range(0, 90)); end
          default: begin hr = 16'($urandom); hg = 16'($urandom); hb = 16'($urandom); end
        endcase
      end
      acc = !m_batch_pending;
      drive(v, c, hr, hg, hb);
      hold = v && !acc && !c;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
